// File: rtl/ysyx_22041412_mem_arb.sv
// Arbiter/sequencer sharing one 128-bit line port between fetch and LSU.
// Optional IF anti-starvation: define YSYX_22041412_ARB_FAIR_EN.
module ysyx_22041412_mem_arb #(
    parameter int ADDR_W     = 32,
    parameter int LINE_W     = 128,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_ready_o,
    output logic [LINE_W-1:0]   if_rdata_o,
    input  logic                ls_valid_i,
    input  logic                ls_wen_i,
    input  logic [ADDR_W-1:0]   ls_addr_i,
    input  logic [LINE_W-1:0]   ls_wdata_i,
    input  logic [LINE_W/8-1:0] ls_wmask_i,
    output logic                ls_ready_o,
    output logic [LINE_W-1:0]   ls_rdata_o,
    output logic                mem_valid_o,
    input  logic                mem_ready_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_wen_o,
    output logic [LINE_W-1:0]   mem_wdata_o,
    output logic [LINE_W/8-1:0] mem_wmask_o,
    input  logic                mem_rvalid_i,
    input  logic [LINE_W-1:0]   mem_rdata_i,
    output logic                busy_o
);

    localparam int MASK_W = LINE_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ_IF,
        REQ_LS,
        RSP_IF,
        RSP_LS,
        DONE
    } state_t;

    state_t state;

    logic if_turn;
    logic grant_ls;
    logic grant_if;

`ifdef YSYX_22041412_ARB_FAIR_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;

    // IF takes the slot once LSU has won STARVE_MAX times in a row over it.
    assign if_turn = if_valid_i && (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (grant_ls && if_valid_i) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end else if (grant_if) begin
                starve_cnt <= '0;
            end
        end
    end
`else
    assign if_turn = 1'b0;
`endif

    assign grant_ls = ls_valid_i && !if_turn;
    assign grant_if = if_valid_i && !grant_ls;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mem_valid_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_wen_o   <= 1'b0;
            mem_wdata_o <= '0;
            mem_wmask_o <= '0;
            if_ready_o  <= 1'b0;
            ls_ready_o  <= 1'b0;
            if_rdata_o  <= '0;
            ls_rdata_o  <= '0;
            busy_o      <= 1'b0;
        end else begin
            if_ready_o <= 1'b0;
            ls_ready_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_ls) begin
                        state       <= REQ_LS;
                        mem_valid_o <= 1'b1;
                        mem_addr_o  <= ls_addr_i;
                        mem_wen_o   <= ls_wen_i;
                        mem_wdata_o <= ls_wdata_i;
                        mem_wmask_o <= ls_wmask_i;
                        busy_o      <= 1'b1;
                    end else if (grant_if) begin
                        state       <= REQ_IF;
                        mem_valid_o <= 1'b1;
                        mem_addr_o  <= {if_addr_i[ADDR_W-1:4], 4'b0};
                        mem_wen_o   <= 1'b0;
                        mem_wdata_o <= '0;
                        mem_wmask_o <= {MASK_W{1'b0}};
                        busy_o      <= 1'b1;
                    end
                end
                REQ_IF: begin
                    if (mem_ready_i) begin
                        state       <= RSP_IF;
                        mem_valid_o <= 1'b0;
                    end
                end
                REQ_LS: begin
                    if (mem_ready_i) begin
                        state       <= RSP_LS;
                        mem_valid_o <= 1'b0;
                    end
                end
                RSP_IF: begin
                    if (mem_rvalid_i) begin
                        state      <= DONE;
                        if_rdata_o <= mem_rdata_i;
                        if_ready_o <= 1'b1;
                    end
                end
                RSP_LS: begin
                    // Write acks also load the line; the LSU ignores it.
                    if (mem_rvalid_i) begin
                        state      <= DONE;
                        ls_rdata_o <= mem_rdata_i;
                        ls_ready_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_mem_arb.sv
// Vector table plus directed sequences for ysyx_22041412_mem_arb.
// A scoreboard queue holds expected ready pulses and lines.
module tb_ysyx_22041412_mem_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic         if_valid_i;
    logic [31:0]  if_addr_i;
    logic         if_ready_o;
    logic [127:0] if_rdata_o;
    logic         ls_valid_i;
    logic         ls_wen_i;
    logic [31:0]  ls_addr_i;
    logic [127:0] ls_wdata_i;
    logic [15:0]  ls_wmask_i;
    logic         ls_ready_o;
    logic [127:0] ls_rdata_o;
    logic         mem_valid_o;
    logic         mem_ready_i;
    logic [31:0]  mem_addr_o;
    logic         mem_wen_o;
    logic [127:0] mem_wdata_o;
    logic [15:0]  mem_wmask_o;
    logic         mem_rvalid_i;
    logic [127:0] mem_rdata_i;
    logic         busy_o;

    ysyx_22041412_mem_arb dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid_i   (if_valid_i),
        .if_addr_i    (if_addr_i),
        .if_ready_o   (if_ready_o),
        .if_rdata_o   (if_rdata_o),
        .ls_valid_i   (ls_valid_i),
        .ls_wen_i     (ls_wen_i),
        .ls_addr_i    (ls_addr_i),
        .ls_wdata_i   (ls_wdata_i),
        .ls_wmask_i   (ls_wmask_i),
        .ls_ready_o   (ls_ready_o),
        .ls_rdata_o   (ls_rdata_o),
        .mem_valid_o  (mem_valid_o),
        .mem_ready_i  (mem_ready_i),
        .mem_addr_o   (mem_addr_o),
        .mem_wen_o    (mem_wen_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_ls;
        logic [127:0] rdata;
    } exp_t;

    typedef struct {
        logic         is_ls;
        logic         wen;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [15:0]  wmask;
        int           rd;
        int           vd;
        logic [127:0] rline;
        logic [31:0]  exp_addr;
    } vec_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every ready pulse must match the oldest expected completion.
    always @(posedge clk) begin
        #1;
        if (if_ready_o || ls_ready_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_ready got if=%b ls=%b want none",
                         if_ready_o, ls_ready_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ready_port", {126'd0, ls_ready_o, if_ready_o},
                    e.is_ls ? 128'd2 : 128'd1);
                chk("rdata", e.is_ls ? ls_rdata_o : if_rdata_o, e.rdata);
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_mem"},
            {94'd0, mem_valid_o, mem_addr_o, mem_wen_o, mem_wmask_o}, 128'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 128'd0);
        chk({tag, "_if_rdata"}, if_rdata_o, 128'd0);
        chk({tag, "_ls_rdata"}, ls_rdata_o, 128'd0);
        chk({tag, "_flags"}, {125'd0, if_ready_o, ls_ready_o, busy_o}, 128'd0);
    endtask

    // Memory side of one transaction; returns in the DONE cycle.
    task automatic serve(input logic is_ls, input logic [31:0] ea,
                         input logic ewen, input logic [127:0] ewd,
                         input logic [15:0] ewm, input int rd, input int vd,
                         input logic [127:0] line, input logic drop);
        int n;
        logic [127:0] want;
        logic [127:0] wd;
        n = 0;
        while (!mem_valid_o && n < 10) begin
            step();
            n++;
        end
        if (!mem_valid_o) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout got idle want mem_valid_o");
            return;
        end
        want = {78'd0, ea, ewen, ewm, 1'b1};
        wd = is_ls ? ewd : 128'd0;
        chk("req_fields", {78'd0, mem_addr_o, mem_wen_o, mem_wmask_o,
                           mem_valid_o}, want);
        chk("req_wdata", is_ls ? mem_wdata_o : 128'd0, wd);
        repeat (rd) begin
            step();
            chk("req_hold", {78'd0, mem_addr_o, mem_wen_o, mem_wmask_o,
                             mem_valid_o}, want);
            chk("req_hold_wdata", is_ls ? mem_wdata_o : 128'd0, wd);
        end
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        chk("rsp_valid_low", {126'd0, mem_valid_o, busy_o}, 128'd1);
        repeat (vd) step();
        mem_rvalid_i = 1'b1;
        mem_rdata_i = line;
        q.push_back('{is_ls: is_ls, rdata: line});
        step();
        mem_rvalid_i = 1'b0;
        mem_rdata_i = JUNK;
        if (drop) begin
            if (is_ls) ls_valid_i = 1'b0;
            else if_valid_i = 1'b0;
        end
        chk("done_busy", {127'd0, busy_o}, 128'd1);
    endtask

    vec_t vt[5];

    initial begin
        logic [127:0] sv_if;
        logic [127:0] sv_ls;
        int t0;
        int cnt;
        logic exp_ls;

        vt[0] = '{1'b0, 1'b0, 32'h8000_0008, 128'd0, 16'h0, 0, 0,
                  128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 32'h8000_0000};
        vt[1] = '{1'b1, 1'b1, 32'h8000_1000, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666,
                  16'h000F, 3, 0, 128'h1, 32'h8000_1000};
        vt[2] = '{1'b1, 1'b0, 32'h8000_2004, 128'h0, 16'h0000, 1, 2,
                  128'hFEDC_BA98_7654_3210_0F0F_F0F0_1234_5678, 32'h8000_2004};
        vt[3] = '{1'b0, 1'b0, 32'h8000_001F, 128'd0, 16'h0, 2, 1,
                  128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA, 32'h8000_0010};
        vt[4] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 128'h0, 16'hFFFF, 0, 0,
                  128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 32'hFFFF_FFFF};

        rst = 1'b1;
        if_valid_i = 1'b0;
        if_addr_i = '0;
        ls_valid_i = 1'b0;
        ls_wen_i = 1'b0;
        ls_addr_i = '0;
        ls_wdata_i = '0;
        ls_wmask_i = '0;
        mem_ready_i = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i = JUNK;
        step();
        step();
        chk_zero("reset");
        rst = 1'b0;
        step();

        foreach (vt[i]) begin
            step();
            if (vt[i].is_ls) begin
                ls_valid_i = 1'b1;
                ls_wen_i = vt[i].wen;
                ls_addr_i = vt[i].addr;
                ls_wdata_i = vt[i].wdata;
                ls_wmask_i = vt[i].wmask;
            end else begin
                if_valid_i = 1'b1;
                if_addr_i = vt[i].addr;
            end
            t0 = cyc;
            serve(vt[i].is_ls, vt[i].exp_addr, vt[i].wen, vt[i].wdata,
                  vt[i].wmask, vt[i].rd, vt[i].vd, vt[i].rline, 1'b1);
            chk("latency", 128'(cyc - t0), 128'(3 + vt[i].rd + vt[i].vd));
            step();
            chk("idle_after", {127'd0, busy_o}, 128'd0);
        end

        // Simultaneous requests: LSU first, IF re-sampled in IDLE after DONE.
        step();
        if_valid_i = 1'b1;
        if_addr_i = 32'h8000_0044;
        ls_valid_i = 1'b1;
        ls_wen_i = 1'b0;
        ls_addr_i = 32'h8000_3000;
        ls_wmask_i = 16'h0;
        step();
        chk("both_first_ls", 128'(mem_addr_o), 128'h8000_3000);
        serve(1'b1, 32'h8000_3000, 1'b0, 128'd0, 16'h0, 0, 0,
              128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b1);
        step();
        chk("both_idle_gap", {126'd0, busy_o, mem_valid_o}, 128'd0);
        step();
        chk("both_then_if", {96'd0, mem_addr_o}, 128'h8000_0040);
        serve(1'b0, 32'h8000_0040, 1'b0, 128'd0, 16'h0, 0, 0,
              128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000, 1'b1);
        step();

        // Both held valid: grant order follows the fairness model.
        if_addr_i = 32'h8000_0100;
        ls_addr_i = 32'h8000_4000;
        if_valid_i = 1'b1;
        ls_valid_i = 1'b1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
`ifdef YSYX_22041412_ARB_FAIR_EN
            exp_ls = (cnt != 4);
            cnt = exp_ls ? cnt + 1 : 0;
`else
            exp_ls = 1'b1;
            cnt = cnt + 1;
`endif
            serve(exp_ls, exp_ls ? 32'h8000_4000 : 32'h8000_0100, 1'b0,
                  128'd0, 16'h0, 0, 0, 128'(k + 100), 1'b0);
        end
        if_valid_i = 1'b0;
        ls_valid_i = 1'b0;
        step();
        step();

        // Spurious rvalid in IDLE.
        sv_if = if_rdata_o;
        sv_ls = ls_rdata_o;
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        chk("spur_idle_busy", {126'd0, busy_o, mem_valid_o}, 128'd0);
        chk("spur_idle_if", if_rdata_o, sv_if);
        chk("spur_idle_ls", ls_rdata_o, sv_ls);

        // Spurious rvalid in REQ_IF.
        if_valid_i = 1'b1;
        if_addr_i = 32'h8000_0208;
        step();
        mem_rvalid_i = 1'b1;
        step();
        mem_rvalid_i = 1'b0;
        chk("spur_req_hold", {126'd0, busy_o, mem_valid_o}, 128'd3);
        chk("spur_req_if", if_rdata_o, sv_if);
        serve(1'b0, 32'h8000_0200, 1'b0, 128'd0, 16'h0, 0, 0,
              128'h0BAD_F00D_0BAD_F00D_0BAD_F00D_0BAD_F00D, 1'b1);
        step();

        // Reset while waiting in RSP_LS; a late rvalid must be ignored.
        ls_valid_i = 1'b1;
        ls_wen_i = 1'b1;
        ls_addr_i = 32'h8000_5000;
        ls_wdata_i = 128'hCAFE;
        ls_wmask_i = 16'h00F0;
        step();
        mem_ready_i = 1'b1;
        step();
        mem_ready_i = 1'b0;
        rst = 1'b1;
        ls_valid_i = 1'b0;
        step();
        rst = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 128'h1234;
        step();
        mem_rvalid_i = 1'b0;
        chk_zero("rst_rsp");
        step();
        chk_zero("rst_rsp_late");

        step();
        chk("queue_empty", 128'(q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
